// File: rtl/rll_seq_key_pipe.sv
// Key-gated input pipeline for a locked benchmark: serially loaded key with
// shadow/commit, per-bit XOR/XNOR polarity folded onto the data word.
module rll_seq_key_pipe #(
  parameter int                DATA_W  = 17,
  parameter int                KEY_W   = 32,
  parameter logic [KEY_W-1:0]  KEY_POL = '0,
  parameter int                STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load_start,
  input  logic              key_sin,
  input  logic              key_sin_valid,
  output logic              key_busy,
  output logic              key_loaded,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [KEY_W-1:0]   ksh, kc, ksh_shift, kc_next, g;
  logic               last_bit, commit, loaded_q;
  logic [DATA_W-1:0]  mask;
  logic [DATA_W-1:0]  pd [STAGES];
  logic [STAGES-1:0]  pv;

  generate
    if (KEY_W == 1) begin : g_shift_1
      assign ksh_shift = key_sin;
    end else begin : g_shift_n
      assign ksh_shift = {ksh[KEY_W-2:0], key_sin};
    end
  endgenerate

  // Valid/ready contract: none -- key_sin_valid and in_valid are one-cycle
  // qualifiers with no backpressure; out_valid qualifies out_data.
  assign last_bit = (cnt == CNT_W'(KEY_W - 1));
  assign commit   = (state == LOAD) && !key_load_start && key_sin_valid && last_bit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_load_start) state_next = LOAD;
      LOAD: begin
        if (key_load_start) state_next = LOAD;
        else if (commit)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_busy   = (state == LOAD);
    key_loaded = loaded_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ksh      <= '0;
      kc       <= '0;
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= commit;
      if (key_load_start) begin
        cnt <= '0;
      end else if (state == LOAD && key_sin_valid) begin
        ksh <= ksh_shift;
        cnt <= cnt + 1'b1;
      end
      if (commit) kc <= ksh_shift;
    end
  end

  // Forward the committing key so the word sampled on the commit edge
  // already sees the new mask; no word is ever split across two keys.
  assign kc_next = commit ? ksh_shift : kc;
  assign g       = kc_next ^ KEY_POL;

  always_comb begin
    mask = '0;
    for (int i = 0; i < KEY_W; i++) begin
      mask[i % DATA_W] = mask[i % DATA_W] ^ g[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) pd[s] <= '0;
      pv <= '0;
    end else begin
      pd[0] <= in_data ^ mask;
      pv[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        pd[s] <= pd[s-1];
        pv[s] <= pv[s-1];
      end
    end
  end

  assign out_data  = pd[STAGES-1];
  assign out_valid = pv[STAGES-1];
endmodule

// File: tb/tb_rll_seq_key_pipe.sv
// Scoreboard bench for rll_seq_key_pipe: per-cycle key FSM model, expected
// data queue filled on drive and drained on out_valid.
module tb_rll_seq_key_pipe;
  localparam int              DW  = 8;
  localparam int              KW  = 16;
  localparam logic [KW-1:0]   POL = 16'hA5C3;
  localparam int              ST  = 2;

  // clock/reset block
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_load_start = 1'b0;
  logic          key_sin = 1'b0;
  logic          key_sin_valid = 1'b0;
  logic          key_busy, key_loaded;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;

  always #5 clk = ~clk;

  rll_seq_key_pipe #(.DATA_W(DW), .KEY_W(KW), .KEY_POL(POL), .STAGES(ST)) dut (
    .clk(clk), .rst(rst),
    .key_load_start(key_load_start), .key_sin(key_sin), .key_sin_valid(key_sin_valid),
    .key_busy(key_busy), .key_loaded(key_loaded),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid)
  );

  // scoreboard and reference state
  logic [DW-1:0] exp_q[$];
  logic          exp_v [ST];
  logic          m_loading;
  int            m_cnt;
  logic [KW-1:0] m_sh, m_kc;
  logic [DW-1:0] last_out;
  int            n_out, n_loaded;
  int            tests_run, tests_failed;

  function automatic logic [DW-1:0] fold(input logic [KW-1:0] k);
    logic [KW-1:0] gk;
    logic [DW-1:0] r;
    gk = k ^ POL;
    for (int j = 0; j < DW; j++) begin
      r[j] = 1'b0;
      for (int i = j; i < KW; i += DW) r[j] = r[j] ^ gk[i];
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, reference update and output checks
  task automatic step(input logic r, input logic st, input logic sb, input logic sv,
                      input logic dv, input logic [DW-1:0] d);
    logic          new_loaded;
    logic [DW-1:0] e;
    int            n;
    @(negedge clk);
    rst = r; key_load_start = st; key_sin = sb; key_sin_valid = sv;
    in_valid = dv; in_data = d;
    @(posedge clk);
    #1;
    new_loaded = 1'b0;
    if (r) begin
      n = 0;
      for (int s = 0; s < ST - 1; s++) if (exp_v[s]) n++;
      repeat (n) e = exp_q.pop_back();
      for (int s = 0; s < ST; s++) exp_v[s] = 1'b0;
      m_loading = 1'b0; m_cnt = 0; m_sh = '0; m_kc = '0;
    end else begin
      if (st) begin
        m_loading = 1'b1;
        m_cnt = 0;
      end else if (m_loading && sv) begin
        m_sh = {m_sh[KW-2:0], sb};
        m_cnt++;
        if (m_cnt == KW) begin
          m_kc = m_sh;
          m_loading = 1'b0;
          new_loaded = 1'b1;
        end
      end
      for (int s = ST - 1; s > 0; s--) exp_v[s] = exp_v[s-1];
      exp_v[0] = dv;
      if (dv) exp_q.push_back(d ^ fold(m_kc));
    end
    check_eq("out_valid", 32'(out_valid), 32'(exp_v[ST-1]));
    check_eq("key_busy", 32'(key_busy), 32'(m_loading));
    check_eq("key_loaded", 32'(key_loaded), 32'(new_loaded));
    if (key_loaded) n_loaded++;
    if (out_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("out_data", 32'(out_data), 32'(e));
        last_out = out_data;
        n_out++;
      end else begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic data(input logic [DW-1:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  // start a load and shift the top nbits of k, optionally gapped and with traffic
  task automatic load_key(input logic [KW-1:0] k, input int nbits, input bit gap, input bit stream);
    step(1'b0, 1'b1, 1'b0, 1'b0, stream, DW'($urandom_range(0, 255)));
    for (int i = KW - 1; i > KW - 1 - nbits; i--) begin
      if (gap) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, stream, DW'($urandom_range(0, 255)));
      step(1'b0, 1'b0, k[i], 1'b1, stream, DW'($urandom_range(0, 255)));
    end
  endtask

  int base_loaded, base_out;

  initial begin
    tests_run = 0; tests_failed = 0; n_out = 0; n_loaded = 0; last_out = '0;
    m_loading = 1'b0; m_cnt = 0; m_sh = '0; m_kc = '0;
    for (int s = 0; s < ST; s++) exp_v[s] = 1'b0;

    // reset state and default mask with kc = 0
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    data(8'h00);
    idle(1);
    check_eq("rst_default", 32'(last_out), 32'h66);

    // correct key makes the pipe transparent
    base_loaded = n_loaded;
    load_key(POL, KW, 1'b0, 1'b0);
    idle(1);
    check_eq("ck_pulses", 32'(n_loaded - base_loaded), 32'd1);
    data(8'h3C);
    data(8'hFF);
    check_eq("ck_3c", 32'(last_out), 32'h3C);
    idle(1);
    check_eq("ck_ff", 32'(last_out), 32'hFF);

    // key_sin_valid in IDLE is ignored, then gapped load with live traffic
    repeat (3) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, DW'($urandom_range(0, 255)));
    base_loaded = n_loaded;
    load_key(16'h0001, KW, 1'b1, 1'b1);
    idle(3);
    check_eq("gap_pulses", 32'(n_loaded - base_loaded), 32'd1);
    data(8'hAA);
    idle(1);
    check_eq("gap_mask67", 32'(last_out), 32'hCD);

    // restart after 9 bits; partial bits must not matter
    load_key(16'h5A5A, 9, 1'b0, 1'b1);
    load_key(POL, KW, 1'b0, 1'b1);
    data(8'h5A);
    idle(1);
    check_eq("restart_transp", 32'(last_out), 32'h5A);

    // reset mid-load clears kc back to zero
    load_key(16'h1234, 5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    idle(1);
    check_eq("rst_mid_busy", 32'(key_busy), 32'd0);
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    data(8'h00);
    idle(1);
    check_eq("rst_mid_mask66", 32'(last_out), 32'h66);

    // back-to-back words with the correct key
    load_key(POL, KW, 1'b0, 1'b0);
    idle(2);
    base_out = n_out;
    for (int i = 0; i < 20; i++) data(DW'($urandom_range(0, 255)));
    idle(3);
    check_eq("b2b_count", 32'(n_out - base_out), 32'd20);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
